add16_sequencer: RTL
====================

Name: add16_sequencer

Overview:
Controller that sequences the team's split-capable 16-bit adder datapath to perform multi-word (multi-precision) additions. Operand word pairs stream in over a valid/ready handshake, least-significant word first. Carry is chained word to word, and sum words stream out over a registered valid/ready port. In split mode the adder runs as two independent 8-bit lanes, each with its own carry chain. The block sits between the operand-fetch logic and the result buffer.

Parameters:
CNT_W, 4, width of num_words; one operation is 1..2^CNT_W-1 words.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin operation; sampled only in IDLE
num_words  input  CNT_W  word count for the operation, sampled with start
split  input  1  1 = two independent 8-bit lanes, 0 = one 16-bit adder; sampled with start
carry_in  input  1  initial carry, sampled with start; fed to both lanes in split mode
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer accepts operand pair this cycle
in_a  input  16  operand A word, bit 15 = MSB
in_b  input  16  operand B word
out_valid  output  1  sum word valid
out_ready  input  1  downstream accepts sum word
out_sum  output  16  sum word
out_last  output  1  marks the final sum word of the operation
carry_out  output  2  final carries; [0] = low lane or full 16-bit carry, [1] = high lane carry (0 when split = 0)
busy  output  1  operation in progress
done  output  1  one-cycle pulse when the operation completes

Behaviour:
- Reset (async): state IDLE; out_valid, out_last, in_ready, busy, done = 0; out_sum = 0; carry_out = 0; internal carry and count registers = 0.
- States:
  - IDLE: on start with num_words != 0, latch num_words, split and carry_in into the carry register(s), then go to RUN. On start with num_words == 0, go to DONE without producing any output; carry_out <= {split & carry_in, carry_in}.
  - RUN: in_ready = !out_valid | out_ready. A transfer happens when in_valid & in_ready. On a transfer:
    - out_sum <= A + B + carry (per lane in split mode).
    - Carry register(s) <= adder carry.
    - out_valid <= 1; the count decrements.
    - On the last word, out_last <= 1 and the state goes to FLUSH.
    - Latency from in transfer to out_valid is 1 cycle. Throughput is 1 word per cycle when out_ready is held at 1.
  - FLUSH: in_ready = 0. When out_valid & out_ready, clear out_valid and out_last, set carry_out <= final carries, and go to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- out_valid rule: in RUN, if an output is accepted and no new input arrives in the same cycle, out_valid falls to 0.
- Holding rule: out_sum and out_last stay stable while out_valid = 1 and out_ready = 0.
- Split lanes:
  - Low lane: S[7:0] = A[7:0] + B[7:0] + c0.
  - High lane: S[15:8] = A[15:8] + B[15:8] + c1.
  - Both c0 and c1 start at carry_in. Carry never crosses bit 7 to bit 8.
- Non-split: 17-bit sum; bit 16 is the chained carry.
- busy: 1 in RUN and FLUSH, 0 in IDLE and DONE.
- start while busy or in DONE is ignored; no queueing.
- carry_out holds its value until the next completion or reset.
- rst asserted mid-operation aborts immediately to the reset values. No partial done pulse is produced, and any pending output is discarded.
- in_valid in IDLE, FLUSH or DONE: in_ready = 0, so no transfer takes place.

Decomposition:
- Shared package add16_pkg:
  - typedef word_t (16-bit).
  - state enum {IDLE, RUN, FLUSH, DONE}.
  - Constants LANE_W = 8 and WORD_W = 16.
- One natural sub-module: add16_split_core. It is combinational, with inputs a, b, c0, c1 and split, and outputs sum[15:0], co0 and co1. The sequencer instantiates it once.

Test Plan:
1. Single word, split = 0, carry_in = 0, A = 0xFFFF, B = 0x0001, out_ready = 1 -> out_sum = 0x0000, out_last = 1, carry_out = 2'b01, done pulses 2 cycles after the input transfer.
2. 3 words, split = 0, carry_in = 1, A = {0xFFFF, 0xFFFF, 0x0000}, B = 0 (LS word first) -> sums 0x0000, 0x0000, 0x0001; carry_out = 2'b00; 3 consecutive out_valid cycles.
3. Split = 1, 2 words, carry_in = 0, A = {0x80FF, 0x0000}, B = {0x8001, 0x0000} -> sums 0x0000 then 0x0101 (per-lane carries applied), carry_out = 2'b00, no cross-lane carry.
4. Backpressure: 4 words with out_ready toggling 0/1 every cycle -> in_ready low while the output is stalled, no word lost or duplicated, out_sum stable while stalled, exactly 4 outputs.
5. num_words = 0 with carry_in = 1, split = 1 -> no out_valid, done pulses next-next cycle, carry_out = 2'b11.
6. rst asserted after word 2 of 4 -> all outputs return to reset values asynchronously, no done pulse; a new start afterwards runs normally.

Source files
------------

// File: rtl/add16_pkg.sv
// Shared types and constants for the multi-word add16 sequencer and its
// split-capable adder core.
package add16_pkg;

    localparam int LANE_W = 8;
    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

endpackage : add16_pkg

// File: rtl/add16_sequencer_if.sv
// Control, operand and result handshake bundle of the add16 sequencer.
// "master" is the operand-fetch/result-buffer side; "slave" is the sequencer.
interface add16_sequencer_if #(
    parameter int CNT_W = 4
);
    import add16_pkg::*;

    logic             start;
    logic [CNT_W-1:0] num_words;
    logic             split;
    logic             carry_in;
    logic             in_valid;
    logic             in_ready;
    word_t            in_a;
    word_t            in_b;
    logic             out_valid;
    logic             out_ready;
    word_t            out_sum;
    logic             out_last;
    logic [1:0]       carry_out;
    logic             busy;
    logic             done;

    modport master (
        output start, num_words, split, carry_in, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_last, carry_out, busy, done
    );

    modport slave (
        input  start, num_words, split, carry_in, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_last, carry_out, busy, done
    );

endinterface : add16_sequencer_if

// File: rtl/add16_split_core.sv
// Combinational 16-bit adder that can run as two independent 8-bit lanes,
// each with its own carry in and carry out.
module add16_split_core
    import add16_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  logic  c0,
    input  logic  c1,
    input  logic  split,
    output word_t sum,
    output logic  co0,
    output logic  co1
);

    logic [LANE_W:0] lo;
    logic [LANE_W:0] hi;
    logic [WORD_W:0] full;

    // NOTE: every always_comb output gets a value on every path (defaults or
    // full if/else), otherwise synthesis infers a latch.
    always_comb begin
        lo   = {1'b0, a[LANE_W-1:0]} + {1'b0, b[LANE_W-1:0]} + {{LANE_W{1'b0}}, c0};
        hi   = {1'b0, a[WORD_W-1:LANE_W]} + {1'b0, b[WORD_W-1:LANE_W]} + {{LANE_W{1'b0}}, c1};
        full = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, c0};
        if (split) begin
            sum = {hi[LANE_W-1:0], lo[LANE_W-1:0]};
            co0 = lo[LANE_W];
            co1 = hi[LANE_W];
        end else begin
            sum = full[WORD_W-1:0];
            co0 = full[WORD_W];
            co1 = 1'b0;
        end
    end

endmodule : add16_split_core

// File: rtl/add16_sequencer.sv
// Multi-precision add sequencer: streams operand word pairs LS word first,
// chains carries through add16_split_core and emits registered sum words.
module add16_sequencer
    import add16_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input logic               clk,
    input logic               rst,
    add16_sequencer_if.slave  bus
);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic             split_q;
    logic             c0;
    logic             c1;
    word_t            out_sum;
    logic             out_valid;
    logic             out_last;
    logic [1:0]       carry_out;

    word_t            core_sum;
    logic             core_co0;
    logic             core_co1;
    logic             in_ready;
    logic             xfer;

    add16_split_core u_core (
        .a     (bus.in_a),
        .b     (bus.in_b),
        .c0    (c0),
        .c1    (c1),
        .split (split_q),
        .sum   (core_sum),
        .co0   (core_co0),
        .co1   (core_co1)
    );

    assign in_ready = (state == RUN) && (!out_valid || bus.out_ready);
    assign xfer     = in_ready && bus.in_valid;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = (bus.num_words == '0) ? DONE : RUN;
            RUN:     if (xfer && count == CNT_W'(1)) next_state = FLUSH;
            FLUSH:   if (out_valid && bus.out_ready) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            split_q   <= 1'b0;
            c0        <= 1'b0;
            c1        <= 1'b0;
            out_sum   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            carry_out <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    if (bus.num_words != '0) begin
                        count   <= bus.num_words;
                        split_q <= bus.split;
                        c0      <= bus.carry_in;
                        c1      <= bus.carry_in;
                    end else begin
                        carry_out <= {bus.split & bus.carry_in, bus.carry_in};
                    end
                end
                RUN: begin
                    if (xfer) begin
                        out_sum   <= core_sum;
                        c0        <= core_co0;
                        c1        <= core_co1;
                        out_valid <= 1'b1;
                        out_last  <= (count == CNT_W'(1));
                        count     <= count - CNT_W'(1);
                    end else if (bus.out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                // c1 is already 0 in 16-bit mode: the core reports no high-lane carry.
                FLUSH: if (out_valid && bus.out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    carry_out <= {c1, c0};
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = out_sum;
    assign bus.out_last  = out_last;
    assign bus.carry_out = carry_out;
    assign bus.busy      = (state == RUN) || (state == FLUSH);
    assign bus.done      = (state == DONE);

endmodule : add16_sequencer
